// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
// Memory-side responder to the control unit's read/write strobes. Each
// single-cycle request drives one SRAM access with a fixed number of wait
// states, then returns a one-cycle completion pulse. Source (read) and
// destination (write) addresses come from two frame pointers that wrap at
// NUM_PIXELS; a completed frame of writes raises o_done.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_start_frame       zero both pointers, clear o_done, abort any access
//   i_re / i_we         read / write request pulses (i_wdata sampled with i_we)
//   o_rdata             last word read, valid from o_read_complete on
//   o_read_complete     one-cycle pulse at end of a read
//   o_write_complete    one-cycle pulse at end of a write
//   o_done              level, set when the wr pointer wraps
//   o_busy              access in progress or write pending
//   o_err               one-cycle pulse, a request was dropped
//   o_mem_*             SRAM address, write data, read/write strobes
//   i_mem_rdata         SRAM read data
module sram_port_ctrl #(
   parameter int unsigned          ADDR_W     = 20,
   parameter int unsigned          DATA_W     = 32,
   parameter int unsigned          READ_LAT   = 2,
   parameter int unsigned          WRITE_LAT  = 2,
   parameter int unsigned          NUM_PIXELS = 16,
   parameter logic [ADDR_W-1:0]    RD_BASE    = '0,
   parameter logic [ADDR_W-1:0]    WR_BASE    = ADDR_W'('h8000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start_frame,
   input  logic              i_re,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_read_complete,
   output logic              o_write_complete,
   output logic              o_done,
   output logic              o_busy,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_ren,
   output logic              o_mem_wen,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int unsigned PTR_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StRdAcc,
      StRdDone,
      StWrAcc,
      StWrDone
   } state_e;

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic                r_pend;
   logic [DATA_W-1:0]   r_pend_data;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_read_complete;
   logic                r_write_complete;
   logic                r_done;
   logic                r_busy;
   logic                r_err;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_mem_ren;
   logic                r_mem_wen;

   logic                w_rd_wrap;
   logic                w_wr_wrap;
   logic [PTR_W-1:0]    w_rd_ptr_nxt;
   logic [PTR_W-1:0]    w_wr_ptr_nxt;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [ADDR_W-1:0]   w_wr_addr;

   assign w_rd_wrap    = (r_rd_ptr == PTR_W'(NUM_PIXELS - 1));
   assign w_wr_wrap    = (r_wr_ptr == PTR_W'(NUM_PIXELS - 1));
   assign w_rd_ptr_nxt = w_rd_wrap ? '0 : r_rd_ptr + 1'b1;
   assign w_wr_ptr_nxt = w_wr_wrap ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_addr    = RD_BASE + ADDR_W'(r_rd_ptr);
   assign w_wr_addr    = WR_BASE + ADDR_W'(r_wr_ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= StIdle;
         r_cnt            <= '0;
         r_rd_ptr         <= '0;
         r_wr_ptr         <= '0;
         r_pend           <= 1'b0;
         r_pend_data      <= '0;
         r_rdata          <= '0;
         r_read_complete  <= 1'b0;
         r_write_complete <= 1'b0;
         r_done           <= 1'b0;
         r_busy           <= 1'b0;
         r_err            <= 1'b0;
         r_mem_addr       <= '0;
         r_mem_wdata      <= '0;
         r_mem_ren        <= 1'b0;
         r_mem_wen        <= 1'b0;
      end else begin
         // Pulses default low; each branch raises what it needs.
         r_read_complete  <= 1'b0;
         r_write_complete <= 1'b0;
         r_err            <= 1'b0;

         if (i_start_frame) begin
            // Frame restart wins over everything, including a same-cycle
            // request, which is silently dropped.
            r_state   <= StIdle;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_done    <= 1'b0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
         end else begin
            if (r_state != StIdle && (i_re || i_we)) begin
               r_err <= 1'b1;
            end
            unique case (r_state)
               StIdle: begin
                  if (i_re) begin
                     r_state    <= StRdAcc;
                     r_cnt      <= CNT_W'(READ_LAT - 1);
                     r_mem_addr <= w_rd_addr;
                     r_mem_ren  <= 1'b1;
                     r_busy     <= 1'b1;
                     // Simultaneous write is parked and served right after.
                     if (i_we) begin
                        r_pend      <= 1'b1;
                        r_pend_data <= i_wdata;
                     end
                  end else if (i_we) begin
                     r_state     <= StWrAcc;
                     r_cnt       <= CNT_W'(WRITE_LAT - 1);
                     r_mem_addr  <= w_wr_addr;
                     r_mem_wdata <= i_wdata;
                     r_mem_wen   <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
               StRdAcc: begin
                  if (r_cnt == '0) begin
                     r_state         <= StRdDone;
                     r_mem_ren       <= 1'b0;
                     r_rdata         <= i_mem_rdata;
                     r_read_complete <= 1'b1;
                     r_rd_ptr        <= w_rd_ptr_nxt;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               StRdDone: begin
                  if (r_pend) begin
                     r_state     <= StWrAcc;
                     r_cnt       <= CNT_W'(WRITE_LAT - 1);
                     r_mem_addr  <= w_wr_addr;
                     r_mem_wdata <= r_pend_data;
                     r_mem_wen   <= 1'b1;
                     r_pend      <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                     r_busy  <= 1'b0;
                  end
               end
               StWrAcc: begin
                  if (r_cnt == '0) begin
                     r_state          <= StWrDone;
                     r_mem_wen        <= 1'b0;
                     r_write_complete <= 1'b1;
                     r_wr_ptr         <= w_wr_ptr_nxt;
                     if (w_wr_wrap) begin
                        r_done <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               StWrDone: begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state   <= StIdle;
                  r_busy    <= 1'b0;
                  r_mem_ren <= 1'b0;
                  r_mem_wen <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_rdata          = r_rdata;
   assign o_read_complete  = r_read_complete;
   assign o_write_complete = r_write_complete;
   assign o_done           = r_done;
   assign o_busy           = r_busy;
   assign o_err            = r_err;
   assign o_mem_addr       = r_mem_addr;
   assign o_mem_wdata      = r_mem_wdata;
   assign o_mem_ren        = r_mem_ren;
   assign o_mem_wen        = r_mem_wen;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: directed requests push expected completions into
// a queue; a negedge monitor pops and compares on every completion pulse.
module tb_sram_port_ctrl;

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 2;
   localparam int unsigned WL = 3;
   localparam int unsigned NP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start_frame = 1'b0;
   logic          i_re = 1'b0;
   logic          i_we = 1'b0;
   logic [DW-1:0] i_wdata = '0;
   logic [DW-1:0] i_mem_rdata = '0;
   logic [DW-1:0] o_rdata;
   logic          o_read_complete;
   logic          o_write_complete;
   logic          o_done;
   logic          o_busy;
   logic          o_err;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic          o_mem_ren;
   logic          o_mem_wen;

   always #5 clk = ~clk;

   sram_port_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .READ_LAT   (RL),
      .WRITE_LAT  (WL),
      .NUM_PIXELS (NP),
      .RD_BASE    (20'h0),
      .WR_BASE    (20'h8000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start_frame    (i_start_frame),
      .i_re             (i_re),
      .i_we             (i_we),
      .i_wdata          (i_wdata),
      .o_rdata          (o_rdata),
      .o_read_complete  (o_read_complete),
      .o_write_complete (o_write_complete),
      .o_done           (o_done),
      .o_busy           (o_busy),
      .o_err            (o_err),
      .o_mem_addr       (o_mem_addr),
      .o_mem_wdata      (o_mem_wdata),
      .o_mem_ren        (o_mem_ren),
      .o_mem_wen        (o_mem_wen),
      .i_mem_rdata      (i_mem_rdata)
   );

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            done;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   err_seen = 0;
   int   err_exp  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: tracks the strobe window of each access and scores completions.
   logic          ren_p = 1'b0;
   logic          wen_p = 1'b0;
   logic [AW-1:0] acc_addr = '0;
   logic [DW-1:0] acc_wdata = '0;
   int            acc_len = 0;
   exp_t          mon_e;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_err) err_seen++;
         if (o_mem_ren || o_mem_wen) check("strobe_excl", 64'(o_mem_ren & o_mem_wen), 64'(0));
         if ((o_mem_ren && !ren_p) || (o_mem_wen && !wen_p)) begin
            acc_addr  = o_mem_addr;
            acc_wdata = o_mem_wdata;
            acc_len   = 0;
         end
         if (o_mem_ren || o_mem_wen) acc_len++;
         if (o_read_complete || o_write_complete) begin
            if (exp_q.size() == 0) begin
               check("unexpected_complete", 64'({o_read_complete, o_write_complete}), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("kind", 64'(o_write_complete), 64'(mon_e.is_wr));
               check("addr", 64'(acc_addr), 64'(mon_e.addr));
               if (mon_e.is_wr) begin
                  check("wdata", 64'(acc_wdata), 64'(mon_e.data));
                  check("wen_len", 64'(acc_len), 64'(WL));
               end else begin
                  check("rdata", 64'(o_rdata), 64'(mon_e.data));
                  check("ren_len", 64'(acc_len), 64'(RL));
               end
               check("latency", 64'(cyc), 64'(mon_e.cyc));
               check("done", 64'(o_done), 64'(mon_e.done));
            end
         end
         ren_p = o_mem_ren;
         wen_p = o_mem_wen;
      end
   end

   // All stimulus tasks start and end positioned at a negedge.
   task automatic start_frame();
      i_start_frame = 1'b1;
      @(negedge clk);
      i_start_frame = 1'b0;
   endtask

   task automatic do_read(input logic [DW-1:0] rdata, input logic [AW-1:0] addr);
      i_mem_rdata = rdata;
      exp_q.push_back('{1'b0, addr, rdata, 1'b0, cyc + 1 + RL});
      i_re = 1'b1;
      @(negedge clk);
      i_re = 1'b0;
   endtask

   task automatic do_write(input logic [DW-1:0] wdata, input logic [AW-1:0] addr,
                           input bit done_exp);
      exp_q.push_back('{1'b1, addr, wdata, done_exp, cyc + 1 + WL});
      i_we    = 1'b1;
      i_wdata = wdata;
      @(negedge clk);
      i_we    = 1'b0;
      i_wdata = ~wdata;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((o_busy || exp_q.size() != 0) && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({name, "_timeout"}, 64'(o_busy || exp_q.size() != 0), 64'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset and idle: everything low.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_ren", 64'(o_mem_ren), 64'(0));
      check("rst_wen", 64'(o_mem_wen), 64'(0));
      check("rst_addr", 64'(o_mem_addr), 64'(0));
      check("rst_wdata", 64'(o_mem_wdata), 64'(0));
      check("rst_rdata", 64'(o_rdata), 64'(0));
      check("rst_rc", 64'(o_read_complete), 64'(0));
      check("rst_wc", 64'(o_write_complete), 64'(0));
      check("rst_done", 64'(o_done), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_err", 64'(o_err), 64'(0));

      // Single read.
      do_read(32'hA5A5_A5A5, 20'h0);
      check("busy_read", 64'(o_busy), 64'(1));
      check("ren_read", 64'(o_mem_ren), 64'(1));
      wait_idle("read1");

      // Read and write together: read first, write chained with no idle gap.
      start_frame();
      i_mem_rdata = 32'h5A5A_0001;
      exp_q.push_back('{1'b0, 20'h0, 32'h5A5A_0001, 1'b0, cyc + 1 + RL});
      exp_q.push_back('{1'b1, 20'h8000, 32'h11, 1'b0, cyc + 1 + RL + 1 + WL});
      i_re = 1'b1;
      i_we = 1'b1;
      i_wdata = 32'h11;
      @(negedge clk);
      i_re = 1'b0;
      i_we = 1'b0;
      i_wdata = 32'hFFFF_FFFF;
      wait_idle("rw_pair");
      check("err_rw_pair", 64'(err_seen), 64'(err_exp));

      // Second read while the first is in flight is dropped with o_err.
      start_frame();
      do_read(32'h1234_5678, 20'h0);
      i_re = 1'b1;
      err_exp++;
      @(negedge clk);
      i_re = 1'b0;
      wait_idle("read_drop");
      check("err_read_drop", 64'(err_seen), 64'(err_exp));
      do_read(32'h0BAD_F00D, 20'h1);
      wait_idle("read_ptr1");

      // A full frame of writes, done on the 4th, then wrap to the base.
      start_frame();
      for (int i = 0; i < NP; i++) begin
         do_write(32'hC0 + 32'(i), 20'h8000 + 20'(i), (i == NP - 1));
         wait_idle("frame_wr");
      end
      check("done_held", 64'(o_done), 64'(1));
      do_write(32'hC4, 20'h8000, 1'b1);
      wait_idle("wrap_wr");
      start_frame();
      check("done_cleared", 64'(o_done), 64'(0));

      // Abort a write mid-access: strobe drops, no completion, next write at base.
      i_we = 1'b1;
      i_wdata = 32'hDEAD;
      @(negedge clk);
      i_we = 1'b0;
      check("abort_wen_on", 64'(o_mem_wen), 64'(1));
      start_frame();
      check("abort_wen_off", 64'(o_mem_wen), 64'(0));
      check("abort_busy", 64'(o_busy), 64'(0));
      repeat (6) @(negedge clk);
      do_write(32'hBEEF, 20'h8000, 1'b0);
      wait_idle("after_abort");

      // Start-frame with a read in idle: read dropped, no error, pointer reset.
      do_read(32'h7777_0000, 20'h0);
      wait_idle("pre_sf_read");
      i_start_frame = 1'b1;
      i_re = 1'b1;
      @(negedge clk);
      i_start_frame = 1'b0;
      i_re = 1'b0;
      check("sf_re_busy", 64'(o_busy), 64'(0));
      check("sf_re_ren", 64'(o_mem_ren), 64'(0));
      repeat (4) @(negedge clk);
      do_read(32'h3333_4444, 20'h0);
      wait_idle("post_sf_read");

      check("err_total", 64'(err_seen), 64'(err_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
